// File: rtl/data_bus_arbiter.sv
// Shares the single-port data RAM between the CPU data port and a DMA/loader port.
// Build option: define DATA_BUS_CPU_PRIORITY_EN for fixed CPU priority (default is round-robin).
module data_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int RAM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_ce_i,
  input  logic              cpu_we_i,
  input  logic [3:0]        cpu_sel_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_data_i,
  output logic [DATA_W-1:0] cpu_data_o,
  output logic              cpu_stall_o,
  input  logic              dma_req_i,
  input  logic              dma_we_i,
  input  logic [3:0]        dma_sel_i,
  input  logic [ADDR_W-1:0] dma_addr_i,
  input  logic [DATA_W-1:0] dma_data_i,
  output logic              dma_ack_o,
  output logic [DATA_W-1:0] dma_data_o,
  output logic              ram_ce_o,
  output logic              ram_we_o,
  output logic [3:0]        ram_sel_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_data_o,
  input  logic [DATA_W-1:0] ram_data_i
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  localparam logic       OWN_CPU  = 1'b0;
  localparam logic       OWN_DMA  = 1'b1;
  localparam logic [1:0] LAT_LOAD = 2'(RAM_LAT - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_owner;
  logic                r_last_owner;
  logic [1:0]          r_lat_cnt;
  logic                r_ram_ce;
  logic                r_ram_we;
  logic [3:0]          r_ram_sel;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic [DATA_W-1:0]   r_ram_data;
  logic [DATA_W-1:0]   r_cpu_data;
  logic [DATA_W-1:0]   r_dma_data;
  logic                r_dma_ack;
  logic                w_cpu_wins;
  logic                w_grant;
  logic                w_complete;

  // Round-robin hands a tie to whoever was not served last; a lone requester always wins.
  always_comb begin
`ifdef DATA_BUS_CPU_PRIORITY_EN
    w_cpu_wins = cpu_ce_i;
`else
    w_cpu_wins = cpu_ce_i & (~dma_req_i | (r_last_owner == OWN_DMA));
`endif
  end

  assign w_grant    = (r_state == IDLE) && (cpu_ce_i || dma_req_i);
  assign w_complete = (r_state == BUSY) && (r_lat_cnt == 2'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_grant) w_state_nxt = BUSY;
      BUSY:    if (w_complete) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner      <= OWN_CPU;
      r_last_owner <= OWN_DMA;
      r_lat_cnt    <= 2'd0;
      r_ram_ce     <= 1'b0;
      r_ram_we     <= 1'b0;
      r_ram_sel    <= '0;
      r_ram_addr   <= '0;
      r_ram_data   <= '0;
      r_cpu_data   <= '0;
      r_dma_data   <= '0;
      r_dma_ack    <= 1'b0;
    end else begin
      r_dma_ack <= 1'b0;
      if (w_grant) begin
        r_owner   <= w_cpu_wins ? OWN_CPU : OWN_DMA;
        r_lat_cnt <= LAT_LOAD;
        r_ram_ce  <= 1'b1;
        if (w_cpu_wins) begin
          r_ram_we   <= cpu_we_i;
          r_ram_sel  <= cpu_sel_i;
          r_ram_addr <= cpu_addr_i;
          r_ram_data <= cpu_data_i;
        end else begin
          r_ram_we   <= dma_we_i;
          r_ram_sel  <= dma_sel_i;
          r_ram_addr <= dma_addr_i;
          r_ram_data <= dma_data_i;
        end
      end else if (w_complete) begin
        // Writes leave the read-data registers holding the previous read.
        r_ram_ce     <= 1'b0;
        r_ram_we     <= 1'b0;
        r_last_owner <= r_owner;
        r_dma_ack    <= (r_owner == OWN_DMA);
        if (!r_ram_we) begin
          if (r_owner == OWN_CPU) r_cpu_data <= ram_data_i;
          else                    r_dma_data <= ram_data_i;
        end
      end else if (r_state == BUSY) begin
        r_lat_cnt <= r_lat_cnt - 2'd1;
      end
    end
  end

  assign cpu_stall_o = cpu_ce_i && !((r_state == DONE) && (r_owner == OWN_CPU));
  assign cpu_data_o  = r_cpu_data;
  assign dma_ack_o   = r_dma_ack;
  assign dma_data_o  = r_dma_data;
  assign ram_ce_o    = r_ram_ce;
  assign ram_we_o    = r_ram_we;
  assign ram_sel_o   = r_ram_sel;
  assign ram_addr_o  = r_ram_addr;
  assign ram_data_o  = r_ram_data;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Bench for data_bus_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_data_bus_arbiter;

  localparam int LAT = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_ce_i, cpu_we_i, dma_req_i, dma_we_i;
  logic [3:0]  cpu_sel_i, dma_sel_i;
  logic [31:0] cpu_addr_i, cpu_data_i, dma_addr_i, dma_data_i;
  logic [31:0] cpu_data_o, dma_data_o, ram_addr_o, ram_data_o, ram_data_i;
  logic        cpu_stall_o, dma_ack_o, ram_ce_o, ram_we_o;
  logic [3:0]  ram_sel_o;

  logic        u3_cpu_ce, u3_zero_b;
  logic [3:0]  u3_zero_sel;
  logic [31:0] u3_cpu_addr, u3_zero_w;
  logic [31:0] u3_cpu_data, u3_dma_data, u3_ram_addr, u3_ram_data, u3_ram_rdata;
  logic        u3_stall, u3_dma_ack, u3_ram_ce, u3_ram_we;
  logic [3:0]  u3_ram_sel;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_LAT(LAT)) u_dut (
    .clk(clk), .rst(rst),
    .cpu_ce_i(cpu_ce_i), .cpu_we_i(cpu_we_i), .cpu_sel_i(cpu_sel_i), .cpu_addr_i(cpu_addr_i),
    .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
    .dma_req_i(dma_req_i), .dma_we_i(dma_we_i), .dma_sel_i(dma_sel_i), .dma_addr_i(dma_addr_i),
    .dma_data_i(dma_data_i), .dma_ack_o(dma_ack_o), .dma_data_o(dma_data_o),
    .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o), .ram_sel_o(ram_sel_o), .ram_addr_o(ram_addr_o),
    .ram_data_o(ram_data_o), .ram_data_i(ram_data_i)
  );

  data_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .cpu_ce_i(u3_cpu_ce), .cpu_we_i(u3_zero_b), .cpu_sel_i(4'hF), .cpu_addr_i(u3_cpu_addr),
    .cpu_data_i(u3_zero_w), .cpu_data_o(u3_cpu_data), .cpu_stall_o(u3_stall),
    .dma_req_i(u3_zero_b), .dma_we_i(u3_zero_b), .dma_sel_i(u3_zero_sel), .dma_addr_i(u3_zero_w),
    .dma_data_i(u3_zero_w), .dma_ack_o(u3_dma_ack), .dma_data_o(u3_dma_data),
    .ram_ce_o(u3_ram_ce), .ram_we_o(u3_ram_we), .ram_sel_o(u3_ram_sel), .ram_addr_o(u3_ram_addr),
    .ram_data_o(u3_ram_data), .ram_data_i(u3_ram_rdata)
  );

  function automatic logic [31:0] init_word(input int i);
    return (i == 4) ? 32'hDEADBEEF : (32'h5A5A0000 ^ (32'(i) * 32'h00011111));
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // RAM device for the RAM_LAT=1 instance: data is only valid once ce has been high LAT cycles.
  logic [31:0] mem [16];
  bit          mem_ready;
  int          rcnt;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
      mem_ready <= 1'b1;
    end
    if (ram_ce_o) begin
      if (ram_we_o && rcnt == LAT - 1)
        mem[ram_addr_o[5:2]] <= merge(mem[ram_addr_o[5:2]], ram_data_o, ram_sel_o);
      rcnt <= rcnt + 1;
    end else begin
      rcnt <= 0;
    end
  end
  assign ram_data_i = (ram_ce_o && rcnt >= LAT - 1) ? mem[ram_addr_o[5:2]] : 32'hBAD0BAD0;

  int r3cnt;
  always @(posedge clk) begin
    if (u3_ram_ce) r3cnt <= r3cnt + 1;
    else           r3cnt <= 0;
  end
  assign u3_ram_rdata = (u3_ram_ce && r3cnt >= 2) ? (32'hC0FFEE00 ^ u3_ram_addr) : 32'hBAD0BAD0;

  // Transaction-level reference: a granted access occupies the RAM for cycles start+1..start+LAT
  // and finishes in cycle start+LAT+1; a new grant is only possible in a cycle after that.
  int          cyc = 0;
  int          m_start;
  bit          m_active, m_owner_dma, m_last_dma, m_we;
  logic [31:0] m_addr;
  logic [31:0] e_addr, e_wdata, e_cpu, e_dma;
  logic [3:0]  e_sel;
  bit          m_cpu_done, m_dma_ack, m_dma_busy;
  logic [31:0] ref_mem [16];

  initial begin : model
    bit in_busy, in_done, win_dma;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        m_active = 0; m_last_dma = 1; m_cpu_done = 0; m_dma_ack = 0; m_dma_busy = 0;
        e_addr = 0; e_wdata = 0; e_sel = 0; e_cpu = 0; e_dma = 0;
        chk("rst_ram_ce", ram_ce_o, 0);
        chk("rst_ram_we", ram_we_o, 0);
        chk("rst_ram_addr", ram_addr_o, 0);
        chk("rst_cpu_data", cpu_data_o, 0);
        chk("rst_dma_ack", dma_ack_o, 0);
        chk("rst_dma_data", dma_data_o, 0);
        chk("rst_stall", cpu_stall_o, cpu_ce_i);
      end else begin
        in_busy    = m_active && cyc >= m_start + 1 && cyc <= m_start + LAT;
        in_done    = m_active && cyc == m_start + LAT + 1;
        m_cpu_done = in_done && !m_owner_dma;
        m_dma_ack  = in_done && m_owner_dma;
        chk("m_ram_ce", ram_ce_o, in_busy);
        chk("m_ram_we", ram_we_o, in_busy && m_we);
        chk("m_ram_sel", ram_sel_o, e_sel);
        chk("m_ram_addr", ram_addr_o, e_addr);
        chk("m_ram_wdata", ram_data_o, e_wdata);
        chk("m_cpu_data", cpu_data_o, e_cpu);
        chk("m_dma_data", dma_data_o, e_dma);
        chk("m_dma_ack", dma_ack_o, m_dma_ack);
        chk("m_stall", cpu_stall_o, cpu_ce_i && !m_cpu_done);
        if (in_busy && cyc == m_start + LAT) begin
          if (m_we) ref_mem[m_addr[5:2]] = merge(ref_mem[m_addr[5:2]], e_wdata, e_sel);
          else if (m_owner_dma) e_dma = ref_mem[m_addr[5:2]];
          else e_cpu = ref_mem[m_addr[5:2]];
          m_last_dma = m_owner_dma;
        end
        if (in_done) begin
          m_active = 0;
        end else if (!m_active && (cpu_ce_i || dma_req_i)) begin
`ifdef DATA_BUS_CPU_PRIORITY_EN
          win_dma = !cpu_ce_i;
`else
          if (cpu_ce_i && dma_req_i) win_dma = !m_last_dma;
          else win_dma = dma_req_i;
`endif
          m_active = 1; m_start = cyc; m_owner_dma = win_dma;
          m_we    = win_dma ? dma_we_i : cpu_we_i;
          m_addr  = win_dma ? dma_addr_i : cpu_addr_i;
          e_addr  = m_addr;
          e_sel   = win_dma ? dma_sel_i : cpu_sel_i;
          e_wdata = win_dma ? dma_data_i : cpu_data_i;
        end
        m_dma_busy = m_active && m_owner_dma;
      end
    end
  end

  task automatic cyc_wait();
    @(posedge clk);
    #1;
  endtask

  task automatic new_cpu();
    cpu_ce_i = 1; cpu_we_i = 1'($urandom_range(0, 1)); cpu_sel_i = 4'($urandom_range(1, 15));
    cpu_addr_i = $urandom() & 32'hFFFF_FFFC; cpu_data_i = $urandom();
  endtask

  task automatic new_dma();
    dma_req_i = 1; dma_we_i = 1'($urandom_range(0, 1)); dma_sel_i = 4'($urandom_range(1, 15));
    dma_addr_i = $urandom() & 32'hFFFF_FFFC; dma_data_i = $urandom();
  endtask

  initial begin : stim
    int ng, n_ce, n_st;
    bit prev_ce, done_seen, dropped;
    bit grants [4];
    rst = 0;
    cpu_ce_i = 0; cpu_we_i = 0; cpu_sel_i = 0; cpu_addr_i = 0; cpu_data_i = 0;
    dma_req_i = 0; dma_we_i = 0; dma_sel_i = 0; dma_addr_i = 0; dma_data_i = 0;
    u3_cpu_ce = 0; u3_cpu_addr = 0; u3_zero_b = 0; u3_zero_sel = 0; u3_zero_w = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1;
    @(negedge clk);
    chk("reset_ram_ce", ram_ce_o, 0);
    chk("reset_cpu_data", cpu_data_o, 0);
    chk("reset_dma_ack", dma_ack_o, 0);

    // CPU read of 0x10
    cyc_wait(); cpu_ce_i = 1; cpu_we_i = 0; cpu_sel_i = 4'hF; cpu_addr_i = 32'h10;
    @(negedge clk); chk("t1_c0_stall", cpu_stall_o, 1); chk("t1_c0_ce", ram_ce_o, 0);
    cyc_wait(); @(negedge clk);
    chk("t1_c1_ce", ram_ce_o, 1); chk("t1_c1_stall", cpu_stall_o, 1); chk("t1_c1_addr", ram_addr_o, 32'h10);
    cyc_wait(); @(negedge clk);
    chk("t1_c2_ce", ram_ce_o, 0); chk("t1_c2_stall", cpu_stall_o, 0); chk("t1_c2_data", cpu_data_o, 32'hDEADBEEF);
    cyc_wait(); cpu_ce_i = 0;

    // DMA write then readback of 0x20
    cyc_wait(); dma_req_i = 1; dma_we_i = 1; dma_sel_i = 4'hF; dma_addr_i = 32'h20; dma_data_i = 32'h12345678;
    cyc_wait(); @(negedge clk);
    chk("t2_we", ram_we_o, 1); chk("t2_addr", ram_addr_o, 32'h20);
    chk("t2_wdata", ram_data_o, 32'h12345678); chk("t2_ack_early", dma_ack_o, 0);
    cyc_wait(); @(negedge clk); chk("t2_ack", dma_ack_o, 1); chk("t2_ce_off", ram_ce_o, 0);
    cyc_wait(); dma_req_i = 0; @(negedge clk); chk("t2_ack_once", dma_ack_o, 0);
    cyc_wait(); dma_req_i = 1; dma_we_i = 0;
    cyc_wait(); cyc_wait(); @(negedge clk);
    chk("t2_rd_ack", dma_ack_o, 1); chk("t2_rd_data", dma_data_o, 32'h12345678);
    cyc_wait(); dma_req_i = 0;

    // DMA drops its request one cycle into BUSY
    cyc_wait(); dma_req_i = 1; dma_we_i = 0; dma_addr_i = 32'h28;
    cyc_wait(); dma_req_i = 0; @(negedge clk); chk("t6_busy_ce", ram_ce_o, 1);
    cyc_wait(); @(negedge clk); chk("t6_ack", dma_ack_o, 1);
    cyc_wait(); @(negedge clk); chk("t6_ack_once", dma_ack_o, 0); chk("t6_idle_ce", ram_ce_o, 0);

    // Both requesters held high from reset
    cyc_wait(); rst = 0;
    cpu_ce_i = 1; cpu_we_i = 0; cpu_addr_i = 32'h40; dma_req_i = 1; dma_we_i = 0; dma_addr_i = 32'h80;
    cyc_wait(); rst = 1;
    ng = 0; prev_ce = 0;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      @(negedge clk);
      if (ram_ce_o && !prev_ce) begin grants[ng] = (ram_addr_o == 32'h80); ng++; end
      prev_ce = ram_ce_o;
    end
    chk("t3_grant_count", 32'(ng), 4);
    for (int i = 0; i < ng; i++) begin
`ifdef DATA_BUS_CPU_PRIORITY_EN
      chk("t3_grant_owner", {31'd0, grants[i]}, 0);
`else
      chk("t3_grant_owner", {31'd0, grants[i]}, 32'(i % 2));
`endif
    end
    cyc_wait(); cpu_ce_i = 0; dma_req_i = 0;
    repeat (6) cyc_wait();

    // Reset during BUSY of a DMA read
    dma_req_i = 1; dma_we_i = 0; dma_addr_i = 32'h24;
    cyc_wait();
    #1 rst = 0;
    #1 chk("t5_abort_ce", ram_ce_o, 0); chk("t5_abort_ack", dma_ack_o, 0);
    dma_req_i = 0;
    cyc_wait();
    #1 rst = 1;
    cpu_ce_i = 1; cpu_we_i = 0; cpu_addr_i = 32'h30; dma_req_i = 1; dma_we_i = 0; dma_addr_i = 32'h34;
    @(negedge clk); chk("t5_rel_ack", dma_ack_o, 0);
    cyc_wait(); @(negedge clk);
    chk("t5_tie_ce", ram_ce_o, 1); chk("t5_tie_cpu", ram_addr_o, 32'h30); chk("t5_no_ack", dma_ack_o, 0);
    cyc_wait();
    cyc_wait(); cpu_ce_i = 0;
    cyc_wait();
    cyc_wait(); @(negedge clk); chk("t5_dma_ack", dma_ack_o, 1);
    cyc_wait(); dma_req_i = 0;

    // RAM_LAT=3 instance, CPU read
    cyc_wait(); u3_cpu_ce = 1; u3_cpu_addr = 32'h44;
    n_ce = 0; n_st = 0; done_seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (u3_ram_ce) begin n_ce++; chk("lat3_addr", u3_ram_addr, 32'h44); chk("lat3_we", u3_ram_we, 0); end
      if (u3_stall) n_st++;
      else if (u3_cpu_ce) begin done_seen = 1; chk("lat3_rdata", u3_cpu_data, 32'hC0FFEE44); end
      chk("lat3_no_ack", {u3_dma_ack, u3_dma_data[30:0]}, 0);
      cyc_wait();
      if (done_seen) u3_cpu_ce = 0;
    end
    chk("lat3_ce_cycles", 32'(n_ce), 3);
    chk("lat3_stall_cycles", 32'(n_st), 4);
    chk("lat3_sel_data", {u3_ram_sel, u3_ram_data[27:0]}, 32'hF000_0000);

    // Randomized traffic
    cpu_ce_i = 0; dma_req_i = 0; dropped = 0;
    repeat (3) cyc_wait();
    for (int c = 0; c < 3000; c++) begin
      cyc_wait();
      if (cpu_ce_i) begin
        if (m_cpu_done) begin
          if ($urandom_range(0, 2) == 0) new_cpu();
          else cpu_ce_i = 0;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        new_cpu();
      end
      if (m_dma_ack) begin
        dropped = 0;
        if ($urandom_range(0, 2) == 0) new_dma();
        else dma_req_i = 0;
      end else if (dma_req_i) begin
        if (m_dma_busy && $urandom_range(0, 7) == 0) begin dma_req_i = 0; dropped = 1; end
      end else if (!dropped && $urandom_range(0, 3) == 0) begin
        new_dma();
      end
    end
    cyc_wait(); cpu_ce_i = 0; dma_req_i = 0;
    repeat (8) cyc_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_bus_arbiter.md
Name: data_bus_arbiter

Overview:
- Shares the single-port data RAM between two requesters: the CPU memory-stage data port and a DMA/debug loader port.
- Sits between the CPU core's ram_* bus and the data_ram.
- Sequences each access through a small FSM and stalls the CPU (cpu_stall_o to pc_reg) while its access is pending.
- Returns read data to the requester that issued the access.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
RAM_LAT, 1, cycles from ram_ce_o asserted to valid ram_data_i; legal 1..3

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
cpu_ce_i  in  1  CPU access request, held until cpu_stall_o low
cpu_we_i  in  1  CPU write enable
cpu_sel_i  in  4  CPU byte select
cpu_addr_i  in  ADDR_W  CPU address
cpu_data_i  in  DATA_W  CPU write data
cpu_data_o  out  DATA_W  CPU read data, valid while cpu_stall_o low after a read
cpu_stall_o  out  1  CPU must hold PC and request
dma_req_i  in  1  DMA request, held until dma_ack_o
dma_we_i  in  1  DMA write enable
dma_sel_i  in  4  DMA byte select
dma_addr_i  in  ADDR_W  DMA address
dma_data_i  in  DATA_W  DMA write data
dma_ack_o  out  1  one-cycle completion pulse
dma_data_o  out  DATA_W  DMA read data, valid with dma_ack_o
ram_ce_o  out  1  RAM chip enable
ram_we_o  out  1  RAM write enable
ram_sel_o  out  4  RAM byte select
ram_addr_o  out  ADDR_W  RAM address
ram_data_o  out  DATA_W  RAM write data
ram_data_i  in  DATA_W  RAM read data

Behaviour:
- Reset (rst=0, async): state IDLE; last_owner=DMA, so the CPU wins the first tie; lat_cnt=0.
  - All registered outputs 0: ram_*, cpu_data_o, dma_ack_o, dma_data_o.
  - Reset mid-transaction aborts the access immediately; ram_ce_o drops without waiting for clk.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: if no request, stay in IDLE. Otherwise pick the winner, register its ce/we/sel/addr/data onto ram_*_o, set owner, load lat_cnt=RAM_LAT-1, go to BUSY.
  - Arbitration (default round-robin): if only one requester is active, it wins. If both are active, the one that is not last_owner wins.
  - BUSY: ram_* held stable and ram_ce_o=1. When lat_cnt==0: capture ram_data_i into cpu_data_o or dma_data_o according to owner, drop ram_ce_o/ram_we_o, update last_owner=owner, go to DONE. Otherwise decrement lat_cnt.
  - DONE: one cycle. If owner=DMA, dma_ack_o=1. Then go to IDLE; no arbitration happens in DONE.
- cpu_stall_o is combinational: cpu_ce_i && !(state==DONE && owner==CPU).
- Uncontended CPU access: request in cycle 0 (IDLE), stall high in cycles 0..RAM_LAT, low in cycle RAM_LAT+1.
- Writes take the same latency as reads. Read-data registers are updated only on reads; writes leave the previous value.
- dma_req_i still high in the IDLE cycle after ack is a new request. The DMA master must drop req in the ack cycle for a single access.
- Requester deasserting mid-transaction: the access still completes. An ack is still pulsed for DMA; nothing is signalled to the CPU.
- ram_*_o change only on IDLE→BUSY and BUSY→DONE transitions.

Optional Feature:
DATA_BUS_CPU_PRIORITY_EN:
- Defined: fixed priority; the CPU wins every tie regardless of last_owner. The DMA is served only when cpu_ce_i is low in IDLE.
- Undefined: round-robin as above.

Test Plan:
- Reset release, CPU read addr 0x10, RAM_LAT=1, RAM returns 0xDEADBEEF -> ram_ce_o high cycle 1 only, cpu_stall_o high cycles 0-1, low cycle 2 with cpu_data_o=0xDEADBEEF.
- DMA write addr 0x20 data 0x12345678 sel 4'hF -> ram_we_o=1, ram_addr_o=0x20 for RAM_LAT cycles, dma_ack_o single pulse, RAM reads back 0x12345678.
- cpu_ce_i and dma_req_i both held high from reset, read loop -> grants alternate CPU, DMA, CPU, DMA; CPU first. With DATA_BUS_CPU_PRIORITY_EN, DMA is never granted while cpu_ce_i stays high.
- RAM_LAT=3, CPU read -> ram_ce_o high exactly 3 cycles, cpu_stall_o high 4 cycles, ram_addr_o stable throughout.
- rst driven low during BUSY of a DMA read (between clock edges) -> ram_ce_o and dma_ack_o 0 immediately. After release, no ack for the aborted access and the first tie goes to the CPU.
- DMA drops dma_req_i one cycle into BUSY -> access completes, dma_ack_o still pulses once, FSM returns to IDLE.
